// File: rtl/llc_set_writeback_pkg.sv
// llc_set_writeback_pkg
//   Shared LLC geometry constants and types used by the set write-back
//   block and its buffer sub-module: way/set/tag/state widths, the cache
//   line state encodings and the write-back FSM state type.
package llc_set_writeback_pkg;

    localparam int LLC_WAYS       = 8;
    localparam int LLC_WAY_BITS   = 3;
    localparam int LLC_SET_BITS   = 8;
    localparam int LLC_TAG_BITS   = 16;
    localparam int LLC_STATE_BITS = 3;

    typedef logic [LLC_SET_BITS-1:0]   llc_set_t;
    typedef logic [LLC_TAG_BITS-1:0]   llc_tag_t;
    typedef logic [LLC_STATE_BITS-1:0] llc_state_t;
    typedef logic [LLC_WAY_BITS-1:0]   llc_way_t;

    localparam llc_state_t INVALID = 3'd0;
    localparam llc_state_t VALID   = 3'd1;
    localparam llc_state_t SHARED  = 3'd2;
    localparam llc_state_t EXCL    = 3'd3;
    localparam llc_state_t MODIFY  = 3'd4;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_SCAN  = 2'd1,
        WB_EVICT = 2'd2,
        WB_DONE  = 2'd3
    } llc_wb_state_t;

endpackage

// File: rtl/llc_set_writeback_bufs.sv
// llc_set_bufs
//   Per-set working buffers: tags, states, eviction pointer, set index and
//   the dirty flags that record which entries must be written back.
//   Ports:
//     load_en / set_in / tags_in / states_in / evict_way_in : capture a set,
//                                                              clears all dirty
//     upd_en / upd_way / upd_tag / upd_state : overwrite one way, mark dirty
//     evict_adv                              : pointer <= upd_way+1, mark dirty
//     clr_en / clr_way, clr_evict            : clear dirty after a write
//     set_buf, tags_buf, states_buf, evict_way_buf, dirty, evict_dirty : state
//   The caller is responsible for qualifying load/update strobes (priority
//   and FSM gating live in the top level).
module llc_set_bufs
    import llc_set_writeback_pkg::*;
#(
    parameter int WAYS     = LLC_WAYS,
    parameter int WAY_BITS = LLC_WAY_BITS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_en,
    input  logic [LLC_SET_BITS-1:0]              set_in,
    input  logic [WAYS-1:0][LLC_TAG_BITS-1:0]    tags_in,
    input  logic [WAYS-1:0][LLC_STATE_BITS-1:0]  states_in,
    input  logic [WAY_BITS-1:0]                  evict_way_in,
    input  logic                                 upd_en,
    input  logic [WAY_BITS-1:0]                  upd_way,
    input  logic [LLC_TAG_BITS-1:0]              upd_tag,
    input  logic [LLC_STATE_BITS-1:0]            upd_state,
    input  logic                                 evict_adv,
    input  logic                                 clr_en,
    input  logic [WAY_BITS-1:0]                  clr_way,
    input  logic                                 clr_evict,
    output logic [LLC_SET_BITS-1:0]              set_buf,
    output logic [WAYS-1:0][LLC_TAG_BITS-1:0]    tags_buf,
    output logic [WAYS-1:0][LLC_STATE_BITS-1:0]  states_buf,
    output logic [WAY_BITS-1:0]                  evict_way_buf,
    output logic [WAYS-1:0]                      dirty,
    output logic                                 evict_dirty
);

    logic [WAY_BITS-1:0] evict_next;

    // Wrap explicitly so non-power-of-two way counts still stay in range.
    assign evict_next = (upd_way == WAY_BITS'(WAYS-1)) ? '0
                                                       : upd_way + WAY_BITS'(1);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                tags_buf[w]   <= '0;
                states_buf[w] <= INVALID;
                dirty[w]      <= 1'b0;
            end else if (load_en) begin
                tags_buf[w]   <= tags_in[w];
                states_buf[w] <= states_in[w];
                dirty[w]      <= 1'b0;
            end else if (upd_en && upd_way == WAY_BITS'(w)) begin
                tags_buf[w]   <= upd_tag;
                states_buf[w] <= upd_state;
                dirty[w]      <= 1'b1;
            end else if (clr_en && clr_way == WAY_BITS'(w)) begin
                dirty[w]      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_buf       <= '0;
            evict_way_buf <= '0;
            evict_dirty   <= 1'b0;
        end else if (load_en) begin
            set_buf       <= set_in;
            evict_way_buf <= evict_way_in;
            evict_dirty   <= 1'b0;
        end else if (evict_adv) begin
            evict_way_buf <= evict_next;
            evict_dirty   <= 1'b1;
        end else if (clr_evict) begin
            evict_dirty   <= 1'b0;
        end
    end

endmodule

// File: rtl/llc_set_writeback.sv
// llc_set_writeback
//   Holds one LLC set's working copy (via llc_set_bufs) for the way lookup
//   and, on wb_start, walks the ways in order issuing one RAM write per
//   dirty way followed by an optional eviction-pointer write, then pulses
//   wb_done.
//   Ports:
//     clk, rst (async, active low)
//     load_en, set_in, tags_in, states_in, evict_way_in : load a set
//     upd_en, upd_way, upd_tag, upd_state, evict_adv    : per-way updates
//     wb_start                                          : begin write-back
//     wr_ready / wr_valid, wr_evict, wr_set, wr_way, wr_tag, wr_state,
//       wr_evict_way                                    : RAM write port
//     wb_busy, wb_done                                  : status
//     tags_buf, states_buf, evict_way_buf               : buffers to lookup
module llc_set_writeback
    import llc_set_writeback_pkg::*;
#(
    parameter int LLC_WAYS     = llc_set_writeback_pkg::LLC_WAYS,
    parameter int LLC_WAY_BITS = llc_set_writeback_pkg::LLC_WAY_BITS
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    load_en,
    input  logic [LLC_SET_BITS-1:0]                 set_in,
    input  logic [LLC_WAYS-1:0][LLC_TAG_BITS-1:0]   tags_in,
    input  logic [LLC_WAYS-1:0][LLC_STATE_BITS-1:0] states_in,
    input  logic [LLC_WAY_BITS-1:0]                 evict_way_in,
    input  logic                                    upd_en,
    input  logic [LLC_WAY_BITS-1:0]                 upd_way,
    input  logic [LLC_TAG_BITS-1:0]                 upd_tag,
    input  logic [LLC_STATE_BITS-1:0]               upd_state,
    input  logic                                    evict_adv,
    input  logic                                    wb_start,
    input  logic                                    wr_ready,
    output logic                                    wr_valid,
    output logic                                    wr_evict,
    output logic [LLC_SET_BITS-1:0]                 wr_set,
    output logic [LLC_WAY_BITS-1:0]                 wr_way,
    output logic [LLC_TAG_BITS-1:0]                 wr_tag,
    output logic [LLC_STATE_BITS-1:0]               wr_state,
    output logic [LLC_WAY_BITS-1:0]                 wr_evict_way,
    output logic                                    wb_busy,
    output logic                                    wb_done,
    output logic [LLC_WAYS-1:0][LLC_TAG_BITS-1:0]   tags_buf,
    output logic [LLC_WAYS-1:0][LLC_STATE_BITS-1:0] states_buf,
    output logic [LLC_WAY_BITS-1:0]                 evict_way_buf
);

    llc_wb_state_t             state_q, state_d;
    logic [LLC_WAY_BITS-1:0]   cnt_q, cnt_d;
    logic [LLC_WAYS-1:0]       dirty;
    logic                      evict_dirty;
    logic                      clr_en, clr_evict;
    logic                      idle;
    logic                      load_g, upd_g, adv_g;
    logic [LLC_SET_BITS-1:0]   set_buf;

    // Buffers only change in IDLE so the write-back sees a frozen set;
    // a load in the same cycle as an update wins outright.
    assign idle   = (state_q == WB_IDLE);
    assign load_g = idle && load_en;
    assign upd_g  = idle && !load_en && upd_en;
    assign adv_g  = idle && !load_en && evict_adv;

    llc_set_bufs #(
        .WAYS     (LLC_WAYS),
        .WAY_BITS (LLC_WAY_BITS)
    ) u_bufs (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_g),
        .set_in        (set_in),
        .tags_in       (tags_in),
        .states_in     (states_in),
        .evict_way_in  (evict_way_in),
        .upd_en        (upd_g),
        .upd_way       (upd_way),
        .upd_tag       (upd_tag),
        .upd_state     (upd_state),
        .evict_adv     (adv_g),
        .clr_en        (clr_en),
        .clr_way       (cnt_q),
        .clr_evict     (clr_evict),
        .set_buf       (set_buf),
        .tags_buf      (tags_buf),
        .states_buf    (states_buf),
        .evict_way_buf (evict_way_buf),
        .dirty         (dirty),
        .evict_dirty   (evict_dirty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write payload comes only from registered state; wr_ready only steers
    // the next state and the dirty-clear strobes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clr_en       = 1'b0;
        clr_evict    = 1'b0;
        wr_valid     = 1'b0;
        wr_evict     = 1'b0;
        wr_way       = '0;
        wr_tag       = '0;
        wr_state     = '0;
        wr_evict_way = '0;
        wb_done      = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (wb_start) begin
                    state_d = WB_SCAN;
                    cnt_d   = '0;
                end
            end
            WB_SCAN: begin
                if (dirty[cnt_q]) begin
                    wr_valid = 1'b1;
                    wr_way   = cnt_q;
                    wr_tag   = tags_buf[cnt_q];
                    wr_state = states_buf[cnt_q];
                    clr_en   = wr_ready;
                end
                if (!dirty[cnt_q] || wr_ready) begin
                    // Last way: leave the counter parked rather than wrap.
                    if (cnt_q == LLC_WAY_BITS'(LLC_WAYS-1))
                        state_d = evict_dirty ? WB_EVICT : WB_DONE;
                    else
                        cnt_d = cnt_q + LLC_WAY_BITS'(1);
                end
            end
            WB_EVICT: begin
                wr_valid     = 1'b1;
                wr_evict     = 1'b1;
                wr_evict_way = evict_way_buf;
                if (wr_ready) begin
                    clr_evict = 1'b1;
                    state_d   = WB_DONE;
                end
            end
            WB_DONE: begin
                wb_done = 1'b1;
                state_d = WB_IDLE;
                cnt_d   = '0;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    assign wr_set  = set_buf;
    assign wb_busy = !idle;

endmodule

// File: tb/tb_llc_set_writeback.sv
module tb_llc_set_writeback;
    import llc_set_writeback_pkg::*;

    localparam int NW = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  load_en = 0, upd_en = 0, evict_adv = 0, wb_start = 0, wr_ready = 0;
    logic [7:0]            set_in = '0;
    logic [NW-1:0][15:0]   tags_in = '0;
    logic [NW-1:0][2:0]    states_in = '0;
    logic [2:0]            evict_way_in = '0, upd_way = '0;
    logic [15:0]           upd_tag = '0;
    logic [2:0]            upd_state = '0;
    logic                  wr_valid, wr_evict, wb_busy, wb_done;
    logic [7:0]            wr_set;
    logic [2:0]            wr_way, wr_state, wr_evict_way, evict_way_buf;
    logic [15:0]           wr_tag;
    logic [NW-1:0][15:0]   tags_buf;
    logic [NW-1:0][2:0]    states_buf;

    always #5 clk = ~clk;

    llc_set_writeback #(.LLC_WAYS(NW), .LLC_WAY_BITS(3)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .set_in(set_in), .tags_in(tags_in),
        .states_in(states_in), .evict_way_in(evict_way_in), .upd_en(upd_en),
        .upd_way(upd_way), .upd_tag(upd_tag), .upd_state(upd_state),
        .evict_adv(evict_adv), .wb_start(wb_start), .wr_ready(wr_ready),
        .wr_valid(wr_valid), .wr_evict(wr_evict), .wr_set(wr_set), .wr_way(wr_way),
        .wr_tag(wr_tag), .wr_state(wr_state), .wr_evict_way(wr_evict_way),
        .wb_busy(wb_busy), .wb_done(wb_done), .tags_buf(tags_buf),
        .states_buf(states_buf), .evict_way_buf(evict_way_buf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the set contents plus which entries are modified.
    logic [15:0] m_tag [NW];
    logic [2:0]  m_st  [NW];
    bit          m_dirty [NW];
    logic [2:0]  m_evp;
    bit          m_edirty;
    logic [7:0]  m_set;

    typedef struct {
        bit         ev;
        logic [2:0] way;
        logic [15:0] tag;
        logic [2:0] st;
        logic [2:0] evp;
    } wr_t;

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_tag[w] = '0; m_st[w] = INVALID; m_dirty[w] = 0;
        end
        m_evp = '0; m_edirty = 0; m_set = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [7:0] s, input bit rnd);
        logic [15:0] t;
        logic [2:0]  st;
        set_in = s;
        for (int w = 0; w < NW; w++) begin
            t  = rnd ? 16'($urandom) : 16'(w * 16'h0111);
            st = rnd ? 3'($urandom) : 3'(w % 5);
            tags_in[w] = t; states_in[w] = st;
        end
        evict_way_in = rnd ? 3'($urandom) : 3'd6;
        load_en = 1;
    endtask

    task automatic model_load();
        m_set = set_in;
        for (int w = 0; w < NW; w++) begin
            m_tag[w] = tags_in[w]; m_st[w] = states_in[w]; m_dirty[w] = 0;
        end
        m_evp = evict_way_in; m_edirty = 0;
    endtask

    task automatic do_load(input logic [7:0] s, input bit rnd);
        drive_load(s, rnd);
        tick();
        load_en = 0;
        model_load();
    endtask

    task automatic do_upd(input int way, input logic [15:0] tag, input logic [2:0] st,
                          input bit upd, input bit adv);
        upd_way = 3'(way); upd_tag = tag; upd_state = st;
        upd_en = upd; evict_adv = adv;
        tick();
        upd_en = 0; evict_adv = 0;
        if (upd) begin m_tag[way] = tag; m_st[way] = st; m_dirty[way] = 1; end
        if (adv) begin m_evp = 3'((way + 1) % NW); m_edirty = 1; end
    endtask

    task automatic check_bufs(input string nm);
        for (int w = 0; w < NW; w++) begin
            chk({nm, " tags_buf"}, tags_buf[w], m_tag[w]);
            chk({nm, " states_buf"}, states_buf[w], m_st[w]);
        end
        chk({nm, " evict_way_buf"}, evict_way_buf, m_evp);
    endtask

    // mode 0: ready always; 1: random ready; 2: ready low for the first
    // stall_n cycles in which a write is presented.  poke drives all the
    // IDLE-only controls during the scan, which must have no effect.
    task automatic run_wb(input string nm, input int mode, input int stall_n, input bit poke,
                          output int nwr, output int nstall);
        wr_t exp_q[$];
        wr_t e;
        int  c, done_c, stall_left, ev;
        bit  r;
        for (int w = 0; w < NW; w++)
            if (m_dirty[w]) begin
                e.ev = 0; e.way = 3'(w); e.tag = m_tag[w]; e.st = m_st[w]; e.evp = '0;
                exp_q.push_back(e);
            end
        ev = m_edirty ? 1 : 0;
        if (m_edirty) begin
            e.ev = 1; e.way = '0; e.tag = '0; e.st = '0; e.evp = m_evp;
            exp_q.push_back(e);
        end
        nwr = 0; nstall = 0; done_c = -1; stall_left = stall_n;
        wb_start = 1;
        tick();
        wb_start = 0;
        c = 1;
        while (c < 200) begin
            if (wb_done) begin done_c = c; break; end
            case (mode)
                0:       r = 1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (stall_left == 0);
            endcase
            wr_ready = r;
            if (poke && c == 2) begin
                upd_en = 1; upd_way = 3'd5; upd_tag = 16'hDEAD; upd_state = 3'd2;
                evict_adv = 1; load_en = 1; wb_start = 1;
            end
            if (wr_valid) begin
                if (exp_q.size() == 0) chk({nm, " unexpected write"}, 1, 0);
                else begin
                    e = exp_q[0];
                    if (!e.ev) chk({nm, " tag write"}, {wr_evict, wr_way, wr_tag, wr_state},
                                   {1'b0, e.way, e.tag, e.st});
                    else       chk({nm, " evict write"}, {wr_evict, wr_evict_way}, {1'b1, e.evp});
                    chk({nm, " wr_set"}, wr_set, m_set);
                    if (r) begin void'(exp_q.pop_front()); nwr++; end
                    else begin nstall++; if (stall_left > 0) stall_left--; end
                end
            end
            tick();
            upd_en = 0; evict_adv = 0; load_en = 0; wb_start = 0;
            c++;
        end
        wr_ready = 0;
        if (done_c < 0) chk({nm, " wb_done timeout"}, 0, 1);
        else chk({nm, " wb_done cycle"}, done_c, 9 + nstall + ev);
        chk({nm, " writes outstanding"}, exp_q.size(), 0);
        tick();
        chk({nm, " done one-shot"}, {wb_done, wb_busy}, 2'b00);
        for (int w = 0; w < NW; w++) m_dirty[w] = 0;
        m_edirty = 0;
    endtask

    typedef struct {
        int          way;
        logic [15:0] tag;
        logic [2:0]  st;
        bit          upd;
        bit          adv;
        logic [15:0] exp_tag;
        logic [2:0]  exp_evp;
    } vec_t;

    vec_t tbl[5];
    int   nwr, nstall, k;

    initial begin
        model_reset();
        tick(); tick();
        // Reset state
        chk("reset wr_valid", wr_valid, 0);
        chk("reset busy/done", {wb_busy, wb_done}, 2'b00);
        chk("reset wr_set", wr_set, 0);
        check_bufs("reset");
        rst = 1;
        tick();

        // Nothing loaded: no writes, done at cycle 9
        run_wb("empty", 0, 0, 0, nwr, nstall);
        chk("empty writes", nwr, 0);
        check_bufs("empty");

        // Two dirty ways in order
        do_load(8'h15, 1);
        do_upd(3, 16'h002A, VALID, 1, 0);
        do_upd(6, 16'h0606, MODIFY, 1, 0);
        check_bufs("two-upd");
        run_wb("two-upd", 0, 0, 0, nwr, nstall);
        chk("two-upd writes", nwr, 2);

        // Stalled single write
        do_upd(2, 16'hBEEF, SHARED, 1, 0);
        run_wb("stall", 2, 4, 0, nwr, nstall);
        chk("stall count", nstall, 4);
        chk("stall writes", nwr, 1);

        // Eviction pointer wraps from the last way
        do_upd(7, 16'h0, 3'd0, 0, 1);
        chk("evict wrap buf", evict_way_buf, 3'd0);
        run_wb("evict-wrap", 0, 0, 0, nwr, nstall);
        chk("evict-wrap writes", nwr, 1);

        // Table of buffer updates from a deterministic load
        tbl[0] = '{7, 16'h0BEE, 3'd2, 1, 1, 16'h0BEE, 3'd0};
        tbl[1] = '{2, 16'h1234, 3'd1, 1, 0, 16'h1234, 3'd0};
        tbl[2] = '{0, 16'hFFFF, 3'd3, 0, 1, 16'h0000, 3'd1};
        tbl[3] = '{5, 16'hAAAA, 3'd4, 0, 0, 16'h0555, 3'd1};
        tbl[4] = '{3, 16'h002A, 3'd1, 1, 1, 16'h002A, 3'd4};
        do_load(8'h3C, 0);
        for (int i = 0; i < 5; i++) begin
            do_upd(tbl[i].way, tbl[i].tag, tbl[i].st, tbl[i].upd, tbl[i].adv);
            chk("tbl tag", tags_buf[tbl[i].way], tbl[i].exp_tag);
            chk("tbl evp", evict_way_buf, tbl[i].exp_evp);
        end
        check_bufs("tbl");
        run_wb("tbl", 0, 0, 0, nwr, nstall);
        chk("tbl writes", nwr, 4);

        // Load and update together: load wins, nothing dirty
        drive_load(8'h77, 1);
        upd_en = 1; upd_way = 3'd1; upd_tag = 16'hFFFF; upd_state = 3'd4; evict_adv = 1;
        tick();
        load_en = 0; upd_en = 0; evict_adv = 0;
        model_load();
        check_bufs("load-wins");
        run_wb("load-wins", 0, 0, 0, nwr, nstall);
        chk("load-wins writes", nwr, 0);

        // Controls during the scan are ignored
        do_upd(4, 16'h4444, VALID, 1, 0);
        run_wb("poke", 0, 0, 1, nwr, nstall);
        chk("poke writes", nwr, 1);
        check_bufs("poke");

        // Reset during a stalled write
        do_upd(4, 16'h0404, EXCL, 1, 0);
        wr_ready = 0;
        wb_start = 1;
        tick();
        wb_start = 0;
        k = 0;
        while (!wr_valid && k < 20) begin tick(); k++; end
        chk("pre-reset wr_valid", wr_valid, 1);
        tick();
        rst = 0;
        #1;
        chk("mid-reset wr_valid", wr_valid, 0);
        chk("mid-reset busy", wb_busy, 0);
        model_reset();
        check_bufs("mid-reset");
        tick();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            chk("post-reset no done", {wb_done, wb_busy}, 2'b00);
            tick();
        end
        run_wb("post-reset", 0, 0, 0, nwr, nstall);
        chk("post-reset writes", nwr, 0);

        // Randomized sets, updates and back-pressure
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) do_load(8'($urandom), 1);
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++)
                do_upd($urandom_range(0, NW-1), 16'($urandom), 3'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_bufs("rand");
            run_wb("rand", 1, 0, 0, nwr, nstall);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/llc_set_writeback.md
# llc_set_writeback

Owns the LLC per-set working buffers (tags, states, eviction pointer) that feed the way-lookup logic, and writes modified entries back to the tag/state/eviction RAMs. The LLC controller loads a set, applies per-way updates during request processing, then issues `wb_start`. The block walks the ways in order, emits one RAM write per dirty way plus an optional eviction-pointer write, and pulses `wb_done`.

## Interface
- `LLC_WAYS`, default `` `LLC_WAYS ``: ways per set.
- `LLC_WAY_BITS`, default `` `LLC_WAY_BITS ``: way index width.
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous, active-low.
- `load_en` in 1: capture `tags_in`/`states_in`/`evict_way_in`/`set_in`; clears all dirty flags.
- `set_in` in llc_set_t: set index of the loaded set.
- `tags_in[LLC_WAYS]` in llc_tag_t: tags read from RAM.
- `states_in[LLC_WAYS]` in llc_state_t: states read from RAM.
- `evict_way_in` in llc_way_t: eviction pointer read from RAM.
- `upd_en` in 1: write `upd_tag`/`upd_state` into way `upd_way`; sets that way's dirty flag.
- `upd_way` in llc_way_t: target way.
- `upd_tag` in llc_tag_t: new tag.
- `upd_state` in llc_state_t: new state.
- `evict_adv` in 1: set `evict_way_buf = upd_way + 1` (mod LLC_WAYS); sets evict dirty flag.
- `wb_start` in 1: begin write-back of the buffered set.
- `wr_ready` in 1: RAM accepts the presented write.
- `wr_valid` out 1: write request valid.
- `wr_evict` out 1: 1 = eviction-pointer write; 0 = tag/state write.
- `wr_set` out llc_set_t: set index of the write.
- `wr_way` out llc_way_t: way written (when `wr_evict`=0).
- `wr_tag` out llc_tag_t: tag data.
- `wr_state` out llc_state_t: state data.
- `wr_evict_way` out llc_way_t: eviction-pointer data.
- `wb_busy` out 1: write-back in progress (state ≠ IDLE).
- `wb_done` out 1: one-cycle completion pulse.
- `tags_buf[LLC_WAYS]` out llc_tag_t: buffered tags, to lookup.
- `states_buf[LLC_WAYS]` out llc_state_t: buffered states, to lookup.
- `evict_way_buf` out llc_way_t: buffered eviction pointer, to lookup.

## Operation
- FSM states: IDLE, SCAN, EVICT, DONE.
- IDLE: `load_en`, `upd_en` and `evict_adv` are honoured. Priority when asserted together: `load_en` > `upd_en`/`evict_adv`. `upd_en` and `evict_adv` may coincide. `wb_start` → SCAN with `way_cnt`=0.
- SCAN, clean `way_cnt`: advance one way per cycle.
- SCAN, dirty `way_cnt`:
  - Drive `wr_valid`=1, `wr_evict`=0, `wr_way=way_cnt`, `wr_tag`/`wr_state` from that way's buffer entry.
  - Hold until `wr_valid && wr_ready`. On that cycle clear the dirty flag and advance.
- SCAN exit: after `way_cnt == LLC_WAYS-1` is processed, go to EVICT if the evict flag is set, else DONE. `way_cnt` never wraps.
- EVICT: drive `wr_valid`=1, `wr_evict`=1, `wr_evict_way=evict_way_buf`. On handshake clear the evict flag → DONE.
- DONE: `wb_done`=1 for one cycle → IDLE.
- Outside IDLE: `load_en`, `upd_en`, `evict_adv` and `wb_start` are ignored. Buffers stay stable during write-back.
- `wr_set` always equals the captured `set_in`.
- Eviction-pointer arithmetic: truncate to `LLC_WAY_BITS`, so `upd_way = LLC_WAYS-1` gives 0.

## Timing
- Reset values: all buffers 0 (state 0 = INVALID), dirty flags 0, FSM IDLE, `way_cnt` 0, all outputs 0.
- Buffer updates are registered. They are visible on `*_buf` the cycle after `load_en`/`upd_en`/`evict_adv`.
- `wr_*` outputs are decoded from registered FSM state, `way_cnt` and buffers, with no combinational path from `wr_ready`.
- `wr_valid` is held with stable payload until accepted.
- Latency: `wb_start` at cycle 0, SCAN at cycle 1. Each way takes 1 cycle plus stall cycles. With no dirty entries and `wr_ready`=1, `wb_done` is high at cycle `LLC_WAYS`+1. Each dirty entry adds nothing extra when `wr_ready` is 1.
- Reset asserted mid-write-back: FSM returns to IDLE immediately, `wr_valid` drops, dirty flags clear, no `wb_done`.

## Structure
- `llc_set_t`, `llc_tag_t`, `llc_state_t`, `llc_way_t`, the INVALID encoding and `LLC_WAYS`/`LLC_WAY_BITS` come from the shared cache consts/types headers.
- Add `llc_wb_state_t` (IDLE/SCAN/EVICT/DONE) to the shared types header.
- Sub-module `llc_set_bufs`: buffer registers and dirty flags (load/update/clear ports). The FSM and write port stay in `llc_set_writeback`.

## Test plan
All scenarios use `LLC_WAYS`=8.
- Reset, then `wb_start` with nothing loaded → zero `wr_valid` pulses; `wb_done` at cycle 9; all `*_buf` are 0.
- Load set 0x15, then `upd_en` way 3 (tag 0x2A, state VALID) and way 6, `wr_ready`=1 → exactly two writes, way 3 then way 6, both with `wr_set`=0x15 and correct data; `wb_done` at cycle 9.
- `upd_en` way 2 with `wr_ready` held low for 4 cycles → `wr_valid` and payload stable for 5 cycles; single accept; `wb_done` delayed by 4.
- `evict_adv` with `upd_way`=7 → `evict_way_buf`=0 next cycle; final write has `wr_evict`=1, `wr_evict_way`=0.
- `load_en` and `upd_en` in the same cycle → load wins, no dirty flags. `upd_en`/`wb_start` during SCAN → ignored.
- `rst` low during a stalled dirty write → `wr_valid`=0, FSM IDLE, no `wb_done`; a subsequent `wb_start` issues no writes.
